vga_line_fetch: RTL and testbench

Line prefetcher that sits directly upstream of the VGA scan-out driver. On each line request from the driver it reads one display line of 16-bit pixels from SDRAM through the burst-read port of the memory controller. It writes those pixels into ping-pong line buffer A or B, which the driver then reads back as pixel data on its own clock. The block runs entirely in the system clock domain and resynchronises the driver's request level internally.

---
 rtl/vga_line_fetch.sv | 189 ++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Line prefetcher: on a request from the VGA driver, burst-reads one display line
// from SDRAM and writes it into ping-pong line buffer A or B.
module vga_line_fetch #(
  parameter int                BURST_LEN = 128,
  parameter int                ADDR_W    = 26,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              vga_mode,
  input  logic              read_line_req,
  input  logic              read_line_A_B,
  input  logic [15:0]       read_line_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [7:0]        mem_rd_len,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              buf_wr_en,
  output logic              buf_wr_sel,
  output logic [9:0]        buf_wr_addr,
  output logic [15:0]       buf_wr_data,
  output logic              busy,
  output logic              line_done,
  output logic [7:0]        overrun_cnt
);

  localparam int NB640  = 640 / BURST_LEN;
  localparam int NB1024 = 1024 / BURST_LEN;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  state_t r_state, w_nstate;

  logic              r_s1, r_s2, r_s3, r_start;
  logic              r_sel, r_mode;
  logic [15:0]       r_line;
  logic [10:0]       r_bidx;
  logic [7:0]        r_beat;
  logic [9:0]        r_wr_idx;
  logic              r_p_vld, r_p_sel, r_p_mode;
  logic [15:0]       r_p_line;
  logic              r_abort;
  logic              r_mem_rd_req;
  logic [ADDR_W-1:0] r_mem_rd_addr;
  logic              r_buf_wr_en, r_buf_wr_sel;
  logic [9:0]        r_buf_wr_addr;
  logic [15:0]       r_buf_wr_data;
  logic              r_line_done;
  logic [7:0]        r_ovr;

  logic              w_start, w_ovr, w_ld, w_binc, w_beat_wr;
  logic              w_last_beat, w_last_burst;
  logic              w_src_sel, w_src_mode;
  logic [15:0]       w_src_line, w_line_nx;
  logic [10:0]       w_bidx_nx;
  logic [ADDR_W:0]   w_sum;

  assign w_start      = r_s2 & ~r_s3;
  assign w_ovr        = r_start & (r_state != S_IDLE);
  assign w_beat_wr    = (r_state == S_DATA) & mem_rd_valid;
  assign w_last_beat  = (r_beat == 8'(BURST_LEN - 1));
  assign w_last_burst = (r_bidx == (r_mode ? 11'(NB1024 - 1) : 11'(NB640 - 1)));

  // A request arriving in the same cycle as DONE is newer than any pending one.
  assign w_src_sel  = r_start ? read_line_A_B  : r_p_sel;
  assign w_src_mode = r_start ? vga_mode       : r_p_mode;
  assign w_src_line = r_start ? read_line_addr : r_p_line;

  always_comb begin
    w_nstate = r_state;
    w_ld     = 1'b0;
    w_binc   = 1'b0;
    case (r_state)
      S_IDLE: if (r_start) begin
        w_ld     = 1'b1;
        w_nstate = S_REQ;
      end
      S_REQ:  if (mem_rd_ack) w_nstate = S_DATA;
      S_DATA: if (mem_rd_valid && w_last_beat) begin
        if (w_last_burst || r_abort) w_nstate = S_DONE;
        else begin
          w_binc   = 1'b1;
          w_nstate = S_REQ;
        end
      end
      S_DONE: begin
        if (r_p_vld || r_start) begin
          w_ld     = 1'b1;
          w_nstate = S_REQ;
        end else w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Address of the burst about to be requested, from the post-edge line/burst index.
  assign w_line_nx = w_ld ? w_src_line : r_line;
  assign w_bidx_nx = w_ld ? 11'd0 : (w_binc ? r_bidx + 11'd1 : r_bidx);
  assign w_sum = (ADDR_W+1)'(BASE_ADDR)
               + (ADDR_W+1)'({w_line_nx, 10'd0})
               + (ADDR_W+1)'(32'(w_bidx_nx) * BURST_LEN);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_start       <= 1'b0;
      r_state       <= S_IDLE;
      r_sel         <= 1'b0;
      r_mode        <= 1'b0;
      r_line        <= '0;
      r_bidx        <= '0;
      r_beat        <= '0;
      r_wr_idx      <= '0;
      r_p_vld       <= 1'b0;
      r_p_sel       <= 1'b0;
      r_p_mode      <= 1'b0;
      r_p_line      <= '0;
      r_abort       <= 1'b0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_buf_wr_en   <= 1'b0;
      r_buf_wr_sel  <= 1'b0;
      r_buf_wr_addr <= '0;
      r_buf_wr_data <= '0;
      r_line_done   <= 1'b0;
      r_ovr         <= '0;
    end else begin
      r_s1    <= read_line_req;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_start <= w_start;
      r_state <= w_nstate;
      r_bidx  <= w_bidx_nx;

      if (w_ld) begin
        r_sel  <= w_src_sel;
        r_mode <= w_src_mode;
        r_line <= w_src_line;
      end

      if (r_state == S_REQ && mem_rd_ack) r_beat <= '0;
      else if (w_beat_wr)                 r_beat <= r_beat + 8'd1;

      if (w_ld) r_wr_idx <= '0;
      else if (w_beat_wr && !(w_last_beat && w_last_burst)) r_wr_idx <= r_wr_idx + 10'd1;

      if (w_ld) r_p_vld <= 1'b0;
      else if (w_ovr) begin
        r_p_vld  <= 1'b1;
        r_p_sel  <= read_line_A_B;
        r_p_mode <= vga_mode;
        r_p_line <= read_line_addr;
      end

      if (w_ld)       r_abort <= 1'b0;
      else if (w_ovr) r_abort <= 1'b1;

      if (w_ovr && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;

      r_mem_rd_req <= (w_nstate == S_REQ);
      if (w_nstate == S_REQ) r_mem_rd_addr <= w_sum[ADDR_W-1:0];

      r_buf_wr_en <= w_beat_wr;
      if (w_beat_wr) begin
        r_buf_wr_sel  <= r_sel;
        r_buf_wr_addr <= r_wr_idx;
        r_buf_wr_data <= mem_rd_data;
      end

      r_line_done <= (r_state == S_DONE) && !r_abort;
    end
  end

  assign mem_rd_req  = r_mem_rd_req;
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_rd_len  = 8'(BURST_LEN);
  assign buf_wr_en   = r_buf_wr_en;
  assign buf_wr_sel  = r_buf_wr_sel;
  assign buf_wr_addr = r_buf_wr_addr;
  assign buf_wr_data = r_buf_wr_data;
  assign busy        = (r_state != S_IDLE);
  assign line_done   = r_line_done;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: a behavioural SDRAM responder plus a
// reference model that expands each line request into expected bursts and writes.
module tb_vga_line_fetch;
  localparam int BL = 128;
  localparam int AW = 26;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          vga_mode, read_line_req, read_line_A_B;
  logic [15:0]   read_line_addr;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_len;
  logic          mem_rd_ack, mem_rd_valid;
  logic [15:0]   mem_rd_data;
  logic          buf_wr_en, buf_wr_sel;
  logic [9:0]    buf_wr_addr;
  logic [15:0]   buf_wr_data;
  logic          busy, line_done;
  logic [7:0]    overrun_cnt;

  vga_line_fetch #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .vga_mode(vga_mode),
    .read_line_req(read_line_req), .read_line_A_B(read_line_A_B),
    .read_line_addr(read_line_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .busy(busy), .line_done(line_done),
    .overrun_cnt(overrun_cnt));

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic sel; logic [9:0] addr; logic [15:0] data;} wr_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_addr[$];
  int            done_exp = 0, done_seen = 0;
  int            n_cmp = 0, n_err = 0;
  bit            sb_on = 1'b1;
  int            ack_dly = 2, gap_pct = 0;
  int            acks = 0, wr_seen = 0;

  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    return a[15:0] ^ {a[25:16], 6'h15} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a line is words consecutive pixels from line*1024; nb bursts kept.
  task automatic push_line(input int line, input bit sel, input bit mode, input int nb);
    logic [AW-1:0] base;
    wr_t w;
    base = AW'(line) << 10;
    for (int b = 0; b < nb; b++) exp_addr.push_back(base + AW'(b * BL));
    for (int i = 0; i < nb * BL; i++) begin
      w = {sel, 10'(i), pat(base + AW'(i))};
      exp_wr.push_back(w);
    end
    if (nb * BL == (mode ? 1024 : 640)) done_exp++;
  endtask

  // SDRAM responder: acks after a delay, then streams BL beats with random gaps.
  int            r_ph = 0, r_dly = 0, r_beat = 0;
  logic [AW-1:0] r_ba = '0;
  always @(negedge sys_clk) begin
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    if (sys_rst) r_ph = 0;
    else begin
      if (r_ph == 0 && mem_rd_req) begin
        r_dly = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
        r_ph  = 1;
      end
      if (r_ph == 1) begin
        if (r_dly == 0) begin
          mem_rd_ack = 1'b1;
          acks++;
          r_ba   = mem_rd_addr;
          r_beat = 0;
          r_ph   = 2;
          if (sb_on) begin
            if (exp_addr.size() == 0) chk("unexpected_mem_req", 1, 0);
            else chk("mem_rd_addr", mem_rd_addr, exp_addr.pop_front());
          end
        end else r_dly--;
      end else if (r_ph == 2) begin
        if (int'($urandom_range(0, 99)) >= gap_pct) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = pat(r_ba + AW'(r_beat));
          r_beat++;
          if (r_beat == BL) r_ph = 0;
        end
      end
    end
  end

  // Monitor: pops expected writes and line_done tokens as the DUT presents them.
  always @(negedge sys_clk) begin
    if (buf_wr_en) begin
      wr_seen++;
      if (sb_on) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else chk("buf_wr", {buf_wr_sel, buf_wr_addr, buf_wr_data}, exp_wr.pop_front());
      end
    end
    if (line_done && sb_on) begin
      done_seen++;
      chk("line_done_expected", done_seen <= done_exp, 1);
    end
  end

  task automatic req_start(input int line, input bit sel, input bit mode);
    read_line_addr = 16'(line);
    read_line_A_B  = sel;
    vga_mode       = mode;
    read_line_req  = 1'b1;
  endtask

  task automatic req_drop();
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    repeat (8) @(negedge sys_clk);
    while (busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk({nm, "_timeout"}, n >= budget, 0);
    repeat (2) @(negedge sys_clk);
    chk({nm, "_busy"}, busy, 0);
    if (sb_on) begin
      chk({nm, "_writes_left"}, exp_wr.size(), 0);
      chk({nm, "_reqs_left"}, exp_addr.size(), 0);
      chk({nm, "_line_done"}, done_seen, done_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, n;
    sys_rst = 1'b1; vga_mode = 1'b0; read_line_req = 1'b0;
    read_line_A_B = 1'b0; read_line_addr = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_mem_rd_len", mem_rd_len, BL);
    chk("rst_buf_wr", {buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data}, 0);
    chk("rst_busy_done", {busy, line_done}, 0);
    chk("rst_overrun", overrun_cnt, 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // 640 mode, line 5, buffer B, fixed ack delay, no gaps; request latency; long hold
    ack_dly = 2; gap_pct = 0; a0 = acks; w0 = wr_seen;
    push_line(5, 1'b1, 1'b0, 5);
    req_start(5, 1'b1, 1'b0);
    @(posedge sys_clk);
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (mem_rd_req || n > 10) break;
      n++;
    end
    chk("req_latency", n, 3);
    wait_idle("l640", 3000);
    chk("l640_writes", wr_seen - w0, 640);
    repeat (300) @(negedge sys_clk);
    chk("single_fetch_bursts", acks - a0, 5);
    req_drop();

    // 1024 mode, line 767, buffer A, random ack delay and valid gaps
    ack_dly = -1; gap_pct = 40; w0 = wr_seen;
    push_line(767, 1'b0, 1'b1, 8);
    req_start(767, 1'b0, 1'b1);
    wait_idle("l1024", 8000);
    chk("l1024_writes", wr_seen - w0, 1024);
    req_drop();

    // second request during burst 1: burst 1 drains, rest skipped, new line follows
    ack_dly = 1; gap_pct = 0; a0 = acks;
    push_line(10, 1'b0, 1'b0, 2);
    req_start(10, 1'b0, 1'b0);
    n = 0;
    while (acks - a0 < 2 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ovr_burst1_timeout", n >= 2000, 0);
    req_drop();
    push_line(20, 1'b1, 1'b0, 5);
    req_start(20, 1'b1, 1'b0);
    wait_idle("overrun", 3000);
    chk("overrun_cnt_1", overrun_cnt, 1);
    req_drop();

    // reset in the middle of DATA, then a normal fetch
    ack_dly = 0; w0 = wr_seen;
    push_line(3, 1'b1, 1'b1, 8);
    req_start(3, 1'b1, 1'b1);
    n = 0;
    while (wr_seen - w0 < 50 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("rst_mid_timeout", n >= 2000, 0);
    sys_rst = 1'b1;
    read_line_req = 1'b0;
    @(negedge sys_clk);
    chk("midrst_mem_rd_req", mem_rd_req, 0);
    chk("midrst_buf_wr_en", buf_wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun_cnt, 0);
    exp_wr.delete();
    exp_addr.delete();
    done_exp = done_seen;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    push_line(7, 1'b0, 1'b0, 5);
    req_start(7, 1'b0, 1'b0);
    wait_idle("post_rst", 3000);
    req_drop();

    // 300 requests while busy saturate the overrun counter
    sb_on = 1'b0; ack_dly = 0; gap_pct = 0;
    for (int i = 0; i < 301; i++) begin
      req_start(i % 600, i[0], 1'b0);
      repeat (4) @(negedge sys_clk);
      read_line_req = 1'b0;
      repeat (4) @(negedge sys_clk);
    end
    wait_idle("saturate", 4000);
    chk("overrun_saturate", overrun_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
